// File: rtl/carbonz90_sigport_if.sv
// CPU I/O bus bundle between the core and the signature/poweroff debug port.
// The master drives the request fields; the port answers with rdata and an ack pulse.
interface carbonz90_sigport_if;
  logic       io_req;
  logic       io_we;
  logic [7:0] io_addr;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;
  logic       io_ack;

  modport master (
    output io_req, io_we, io_addr, io_wdata,
    input  io_rdata, io_ack
  );

  modport slave (
    input  io_req, io_we, io_addr, io_wdata,
    output io_rdata, io_ack
  );
endinterface

// File: rtl/carbonz90_sigport.sv
// Debug I/O port: firmware shifts signature bytes in and requests shutdown
// with a keyed two-write sequence. Registers live at BASE_ADDR..BASE_ADDR+3.
module carbonz90_sigport #(
  parameter logic [7:0] BASE_ADDR    = 8'hF0,
  parameter int         ACK_LAT      = 1,
  parameter logic [7:0] POWEROFF_KEY = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  carbonz90_sigport_if.slave   bus,
  output logic [31:0]          signature,
  output logic                 sig_valid,
  output logic                 poweroff
);

  typedef enum logic [1:0] {B_IDLE, B_WAIT, B_ACK, B_RECOVER} bus_st_t;
  typedef enum logic [1:0] {A_DISARMED, A_ARMED, A_FIRED} arm_st_t;

  localparam logic [2:0] LAT_M1 = 3'(ACK_LAT - 1);

  bus_st_t     r_bus_st, w_bus_nxt;
  arm_st_t     r_arm_st, w_arm_nxt;
  logic [2:0]  r_cnt;
  logic [31:0] r_sig;
  logic [2:0]  r_byte_cnt;
  logic [7:0]  r_rdata;
  logic        w_armed;

  logic [7:0]  w_off_full;
  logic [1:0]  w_off;
  logic        w_hit;
  logic        w_do;
  logic        w_wr_po;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v >= 3'd4) ? 3'd4 : v + 3'd1;
  endfunction

  function automatic logic [7:0] read_mux(input logic [1:0]  off,
                                          input logic [31:0] sig,
                                          input logic [2:0]  cnt,
                                          input logic        po,
                                          input logic        armed);
    case (off)
      2'd0:    return sig[7:0];
      2'd1:    return {7'b0, (cnt == 3'd4)};
      2'd2:    return 8'h00;
      default: return {3'b0, po, armed, cnt};
    endcase
  endfunction

  // Modular subtraction keeps the window correct for any BASE_ADDR alignment.
  assign w_off_full = bus.io_addr - BASE_ADDR;
  assign w_hit      = (w_off_full < 8'd4);
  assign w_off      = w_off_full[1:0];
  assign w_do       = (r_bus_st == B_WAIT) && (r_cnt == 3'd0);
  assign w_wr_po    = bus.io_we && (w_off == 2'd2);

  // ---- bus FSM: state register / next state / outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_st <= B_IDLE;
      r_cnt    <= 3'd0;
    end else begin
      r_bus_st <= w_bus_nxt;
      if (r_bus_st == B_IDLE && bus.io_req && w_hit)
        r_cnt <= LAT_M1;
      else if (r_bus_st == B_WAIT && r_cnt != 3'd0)
        r_cnt <= r_cnt - 3'd1;
    end
  end

  always_comb begin
    w_bus_nxt = r_bus_st;
    case (r_bus_st)
      B_IDLE:    if (bus.io_req && w_hit) w_bus_nxt = B_WAIT;
      B_WAIT:    if (r_cnt == 3'd0)       w_bus_nxt = B_ACK;
      B_ACK:                              w_bus_nxt = B_RECOVER;
      B_RECOVER: if (!bus.io_req)         w_bus_nxt = B_IDLE;
      default:                            w_bus_nxt = B_IDLE;
    endcase
  end

  always_comb begin
    bus.io_ack   = (r_bus_st == B_ACK);
    bus.io_rdata = (r_bus_st == B_ACK) ? r_rdata : 8'h00;
  end

  // ---- arm FSM: state register / next state / outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_arm_st <= A_DISARMED;
    else        r_arm_st <= w_arm_nxt;
  end

  always_comb begin
    w_arm_nxt = r_arm_st;
    if (w_do) begin
      case (r_arm_st)
        A_DISARMED:
          if (w_wr_po && bus.io_wdata == POWEROFF_KEY) w_arm_nxt = A_ARMED;
        A_ARMED:
          if (w_wr_po && bus.io_wdata == POWEROFF_KEY)       w_arm_nxt = A_ARMED;
          else if (w_wr_po && bus.io_wdata == ~POWEROFF_KEY) w_arm_nxt = A_FIRED;
          else                                               w_arm_nxt = A_DISARMED;
        A_FIRED:  w_arm_nxt = A_FIRED;
        default:  w_arm_nxt = A_DISARMED;
      endcase
    end
  end

  always_comb begin
    w_armed  = (r_arm_st == A_ARMED);
    poweroff = (r_arm_st == A_FIRED);
  end

  // ---- register file: the access is performed on the edge entering ACK
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig      <= 32'h0;
      r_byte_cnt <= 3'd0;
      r_rdata    <= 8'h00;
    end else if (w_do) begin
      r_rdata <= bus.io_we ? 8'h00
                           : read_mux(w_off, r_sig, r_byte_cnt, poweroff, w_armed);
      // Once poweroff fires the signature is frozen for post-mortem readout.
      if (bus.io_we && !poweroff) begin
        if (w_off == 2'd0) begin
          r_sig      <= {bus.io_wdata, r_sig[31:8]};
          r_byte_cnt <= sat_inc(r_byte_cnt);
        end else if (w_off == 2'd1 && bus.io_wdata[0]) begin
          r_sig      <= 32'h0;
          r_byte_cnt <= 3'd0;
        end
      end
    end
  end

  assign signature = r_sig;
  assign sig_valid = (r_byte_cnt == 3'd4);

endmodule

// File: tb/tb_carbonz90_sigport.sv
// Directed bench for carbonz90_sigport: one instance at ACK_LAT=1 for the
// register behaviour, one at ACK_LAT=3 for latency, reset-abort and decode.
module tb_carbonz90_sigport;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  carbonz90_sigport_if bus1();
  carbonz90_sigport_if bus3();

  logic [31:0] sig1, sig3;
  logic        sv1, sv3, po1, po3;

  carbonz90_sigport #(.BASE_ADDR(8'hF0), .ACK_LAT(1), .POWEROFF_KEY(8'hA5)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .signature(sig1), .sig_valid(sv1), .poweroff(po1)
  );

  carbonz90_sigport #(.BASE_ADDR(8'hF0), .ACK_LAT(3), .POWEROFF_KEY(8'hA5)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3),
    .signature(sig3), .sig_valid(sv3), .poweroff(po3)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  logic [7:0] rd;
  bit         acked;
  logic       po_at_ack;

  // One complete access on the ACK_LAT=1 instance, bounded to 20 cycles.
  task automatic xfer1(input logic we, input logic [7:0] addr, input logic [7:0] wd);
    @(negedge clk);
    bus1.io_req   = 1'b1;
    bus1.io_we    = we;
    bus1.io_addr  = addr;
    bus1.io_wdata = wd;
    acked = 1'b0;
    rd = 8'h00;
    po_at_ack = 1'b0;
    for (int i = 0; i < 20 && !acked; i++) begin
      @(posedge clk); #1;
      if (bus1.io_ack) begin
        acked = 1'b1;
        rd = bus1.io_rdata;
        po_at_ack = po1;
      end
    end
    bus1.io_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  int n;
  int acks;

  initial begin
    bus1.io_req = 0; bus1.io_we = 0; bus1.io_addr = 0; bus1.io_wdata = 0;
    bus3.io_req = 0; bus3.io_we = 0; bus3.io_addr = 0; bus3.io_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_sig", sig1, 32'h0);
    check_val("rst_valid", {31'b0, sv1}, 32'h0);
    check_val("rst_po", {31'b0, po1}, 32'h0);
    check_val("rst_ack", {31'b0, bus1.io_ack}, 32'h0);
    check_val("rst_rdata", {24'b0, bus1.io_rdata}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset asserted while the ACK_LAT=3 instance is counting down.
    @(negedge clk);
    bus3.io_req = 1; bus3.io_we = 1; bus3.io_addr = 8'hF0; bus3.io_wdata = 8'h77;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus3.io_req = 0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (bus3.io_ack) acks++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus3.io_ack) acks++;
    end
    check_val("abort_no_ack", acks, 0);
    check_val("abort_sig", sig3, 32'h0);
    check_val("abort_po", {31'b0, po3}, 32'h0);

    // Signature assembly and saturation.
    xfer1(1, 8'hF0, 8'h5A);
    check_val("w0_ack", {31'b0, acked}, 32'h1);
    check_val("sig_1byte", sig1, 32'h5A000000);
    check_val("valid_1byte", {31'b0, sv1}, 32'h0);
    xfer1(1, 8'hF0, 8'h39);
    xfer1(1, 8'hF0, 8'h30);
    xfer1(1, 8'hF0, 8'h21);
    check_val("sig_4bytes", sig1, 32'h2130395A);
    check_val("valid_4bytes", {31'b0, sv1}, 32'h1);
    xfer1(1, 8'hF0, 8'h11);
    check_val("sig_5bytes", sig1, 32'h11213039);
    xfer1(0, 8'hF3, 8'h00);
    check_val("status_sat", {24'b0, rd}, 32'h04);
    xfer1(0, 8'hF0, 8'h00);
    check_val("rd_sigdata", {24'b0, rd}, 32'h39);
    xfer1(0, 8'hF1, 8'h00);
    check_val("rd_sigctrl", {24'b0, rd}, 32'h01);
    check_val("rdata_idle", {24'b0, bus1.io_rdata}, 32'h0);

    // Clear: a write without bit 0 is ignored, with bit 0 clears.
    xfer1(1, 8'hF1, 8'hFE);
    check_val("ctrl_nobit0", sig1, 32'h11213039);
    xfer1(1, 8'hF1, 8'h01);
    check_val("clr_sig", sig1, 32'h0);
    check_val("clr_valid", {31'b0, sv1}, 32'h0);
    xfer1(0, 8'hF3, 8'h00);
    check_val("clr_status", {24'b0, rd}, 32'h00);

    // Keyed poweroff and frozen signature afterwards.
    xfer1(1, 8'hF0, 8'hC3);
    xfer1(1, 8'hF2, 8'hA5);
    check_val("armed_po", {31'b0, po1}, 32'h0);
    xfer1(1, 8'hF2, 8'h5A);
    check_val("po_in_ack", {31'b0, po_at_ack}, 32'h1);
    check_val("po_sticky", {31'b0, po1}, 32'h1);
    xfer1(1, 8'hF0, 8'hFF);
    check_val("frozen_ack", {31'b0, acked}, 32'h1);
    check_val("frozen_sig", sig1, 32'hC3000000);
    xfer1(1, 8'hF1, 8'h01);
    check_val("frozen_clr", sig1, 32'hC3000000);
    xfer1(0, 8'hF3, 8'h00);
    check_val("fired_status", {24'b0, rd}, 32'h11);
    xfer1(0, 8'hF2, 8'h00);
    check_val("rd_poweroff", {24'b0, rd}, 32'h00);

    // Any intervening access disarms.
    do_reset();
    check_val("rst2_po", {31'b0, po1}, 32'h0);
    xfer1(1, 8'hF2, 8'hA5);
    xfer1(0, 8'hF3, 8'h00);
    check_val("armed_status", {24'b0, rd}, 32'h08);
    xfer1(1, 8'hF2, 8'h5A);
    check_val("disarm_po", {31'b0, po1}, 32'h0);
    xfer1(0, 8'hF3, 8'h00);
    check_val("disarmed_status", {24'b0, rd}, 32'h00);
    xfer1(1, 8'hF2, 8'h5A);
    check_val("trig_unarmed", {31'b0, po1}, 32'h0);
    // Repeated key keeps the port armed.
    xfer1(1, 8'hF2, 8'hA5);
    xfer1(1, 8'hF2, 8'hA5);
    xfer1(1, 8'hF2, 8'h5A);
    check_val("rearm_fire", {31'b0, po1}, 32'h1);

    // Latency, pulse width and no re-execution on the ACK_LAT=3 instance.
    @(negedge clk);
    bus3.io_req = 1; bus3.io_we = 0; bus3.io_addr = 8'hF3; bus3.io_wdata = 8'h00;
    n = 0;
    acked = 1'b0;
    while (n < 20 && !acked) begin
      @(posedge clk); #1;
      n++;
      if (bus3.io_ack) acked = 1'b1;
    end
    check_val("lat3_acked", {31'b0, acked}, 32'h1);
    check_val("lat3_cycles", n, 4);
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus3.io_ack) acks++;
    end
    check_val("lat3_no_reack", acks, 0);
    bus3.io_req = 0;
    repeat (2) @(posedge clk);

    // Address just past the window is never acknowledged.
    @(negedge clk);
    bus3.io_req = 1; bus3.io_we = 1; bus3.io_addr = 8'hF4; bus3.io_wdata = 8'h01;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus3.io_ack) acks++;
    end
    check_val("miss_no_ack", acks, 0);
    bus3.io_req = 0;
    @(negedge clk);
    bus3.io_req = 1; bus3.io_we = 1; bus3.io_addr = 8'hEF; bus3.io_wdata = 8'h01;
    acks = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus3.io_ack) acks++;
    end
    check_val("miss_low_no_ack", acks, 0);
    bus3.io_req = 0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
